// File: rtl/multistage_alu_seq.sv
// Sequenced ALU: operands A/B loaded from the shared OP bus, Gin starts an
// operation through a small FSM; shifts step one bit per edge, optional MUL.
// Latency Gin->G: 2 edges (EXEC), 2+min(B,N) (shifts), N+1 (MUL). No backpressure:
// Gin while BUSY is dropped, nothing is queued; A/B loads are always accepted.
//
// Ports: CLKb clock, RST async active-high reset, OP data bus in (operand or
//   immediate), FN function select (sampled with Gin), Ain/Bin load strobes,
//   Gin start, Gout result-bus enable, RES gated result, BUSY (not IDLE),
//   DONE one-cycle completion pulse, FLAGS registered {Z,N,C,V}.
// Build option: define ALU_MUL_EN to include the shift-add multiplier (FN=1110).
module multistage_alu_seq #(
  parameter int N     = 10,
  parameter int IMM_W = 6
) (
  input  logic         CLKb,
  input  logic         RST,
  input  logic [N-1:0] OP,
  input  logic [3:0]   FN,
  input  logic         Ain,
  input  logic         Bin,
  input  logic         Gin,
  input  logic         Gout,
  output logic [N-1:0] RES,
  output logic         BUSY,
  output logic         DONE,
  output logic [3:0]   FLAGS
);

  localparam int CW = $clog2(N + 1);

  localparam logic [3:0] FN_ADD  = 4'b0010;
  localparam logic [3:0] FN_SUB  = 4'b0011;
  localparam logic [3:0] FN_INV  = 4'b0100;
  localparam logic [3:0] FN_FLP  = 4'b0101;
  localparam logic [3:0] FN_AND  = 4'b0110;
  localparam logic [3:0] FN_OR   = 4'b0111;
  localparam logic [3:0] FN_XOR  = 4'b1000;
  localparam logic [3:0] FN_LSL  = 4'b1001;
  localparam logic [3:0] FN_LSR  = 4'b1010;
  localparam logic [3:0] FN_ASR  = 4'b1011;
  localparam logic [3:0] FN_ADDI = 4'b1100;
  localparam logic [3:0] FN_SUBI = 4'b1101;
`ifdef ALU_MUL_EN
  localparam logic [3:0] FN_MUL  = 4'b1110;
`endif

  localparam logic [N-1:0] N_VAL    = N[N-1:0];
  localparam logic [N-1:0] MSB_ONLY = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    EXEC   = 3'd1,
    SHIFT  = 3'd2,
    DONE_S = 3'd3
`ifdef ALU_MUL_EN
    , MUL  = 3'd4
`endif
  } state_t;

  state_t           state;
  logic [N-1:0]     a, b, g;
  // Working copies taken at start; later A/B loads must not disturb a run.
  logic [3:0]       wfn;
  logic [N-1:0]     wa, wb;
  logic [IMM_W-1:0] wimm;
  logic [CW-1:0]    cnt;
  logic             c_sh;     // last bit shifted out

  logic [N-1:0]     op2;
  logic [N:0]       sum, dif;
  logic [N-1:0]     ex_g;
  logic             ex_c, ex_v;
  logic [3:0]       ex_flags;
  logic             is_shift;

`ifdef ALU_MUL_EN
  logic [2*N-1:0]   mc;       // multiplicand, shifted left each partial product
  logic [2*N-1:0]   acc, acc_nx;
  assign acc_nx = acc + (wb[0] ? mc : '0);
`endif

  assign is_shift = (FN == FN_LSL) || (FN == FN_LSR) || (FN == FN_ASR);
  assign RES      = Gout ? g : '0;

  // Single-cycle result for everything that goes through EXEC.
  always_comb begin
    ex_g = '0;
    ex_c = 1'b0;
    ex_v = 1'b0;
    op2  = ((wfn == FN_ADDI) || (wfn == FN_SUBI)) ? {{(N-IMM_W){1'b0}}, wimm} : wb;
    sum  = {1'b0, wa} + {1'b0, op2};
    dif  = {1'b0, wa} - {1'b0, op2};
    case (wfn)
      FN_ADD, FN_ADDI: begin
        ex_g = sum[N-1:0];
        ex_c = sum[N];
        ex_v = (wa[N-1] == op2[N-1]) && (sum[N-1] != wa[N-1]);
      end
      FN_SUB, FN_SUBI: begin
        ex_g = dif[N-1:0];
        ex_c = ~dif[N];                    // carry = no borrow
        ex_v = (wa[N-1] != op2[N-1]) && (dif[N-1] != wa[N-1]);
      end
      FN_INV: begin
        ex_g = (~wa) + {{(N-1){1'b0}}, 1'b1};
        ex_v = (wa == MSB_ONLY);           // negating the most negative value
      end
      FN_FLP:  ex_g = ~wa;
      FN_AND:  ex_g = wa & wb;
      FN_OR:   ex_g = wa | wb;
      FN_XOR:  ex_g = wa ^ wb;
      default: ex_g = '0;                  // invalid codes: G=0, Z=1
    endcase
    ex_flags = {(ex_g == '0), ex_g[N-1], ex_c, ex_v};
  end

  always_ff @(posedge CLKb or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      a     <= '0;
      b     <= '0;
      g     <= '0;
      FLAGS <= '0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      wfn   <= '0;
      wa    <= '0;
      wb    <= '0;
      wimm  <= '0;
      cnt   <= '0;
      c_sh  <= 1'b0;
`ifdef ALU_MUL_EN
      mc    <= '0;
      acc   <= '0;
`endif
    end else begin
      if (Ain) a <= OP;
      if (Bin) b <= OP;
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (Gin) begin
            wfn  <= FN;
            wa   <= a;
            wb   <= b;
            wimm <= OP[IMM_W-1:0];
            c_sh <= 1'b0;
            cnt  <= (b >= N_VAL) ? CW'(N) : b[CW-1:0];
            BUSY <= 1'b1;
            if (is_shift) begin
              state <= SHIFT;
            end
`ifdef ALU_MUL_EN
            else if (FN == FN_MUL) begin
              state <= MUL;
              cnt   <= CW'(N);
              acc   <= '0;
              mc    <= {{N{1'b0}}, a};
            end
`endif
            else begin
              state <= EXEC;
            end
          end
        end
        EXEC: begin
          g     <= ex_g;
          FLAGS <= ex_flags;
          DONE  <= 1'b1;
          state <= DONE_S;
        end
        SHIFT: begin
          // Count is checked before shifting, so a zero count writes A unchanged.
          if (cnt == '0) begin
            g     <= wa;
            FLAGS <= {(wa == '0), wa[N-1], c_sh, 1'b0};
            DONE  <= 1'b1;
            state <= DONE_S;
          end else begin
            cnt <= cnt - 1'b1;
            case (wfn)
              FN_LSL: begin
                c_sh <= wa[N-1];
                wa   <= {wa[N-2:0], 1'b0};
              end
              FN_ASR: begin
                c_sh <= wa[0];
                wa   <= {wa[N-1], wa[N-1:1]};
              end
              default: begin
                c_sh <= wa[0];
                wa   <= {1'b0, wa[N-1:1]};
              end
            endcase
          end
        end
`ifdef ALU_MUL_EN
        MUL: begin
          // One partial product per edge; the Nth edge also writes the result.
          acc <= acc_nx;
          mc  <= {mc[2*N-2:0], 1'b0};
          wb  <= {1'b0, wb[N-1:1]};
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            g     <= acc_nx[N-1:0];
            FLAGS <= {(acc_nx[N-1:0] == '0), acc_nx[N-1], |acc_nx[2*N-1:N], 1'b0};
            DONE  <= 1'b1;
            state <= DONE_S;
          end
        end
`endif
        DONE_S: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/multistage_alu_seq.md
Name: multistage_alu_seq

Overview:
- Parametrised, sequenced successor to the single-cycle data-bus ALU.
- Operands A and B are latched from the shared OP bus by load strobes. A Gin strobe starts an operation through a small FSM.
- Shifts are iterative, at one bit per cycle. Result G and status flags are registered, and a BUSY/DONE handshake is provided.
- RES drives the shared data bus only while Gout is high.

Parameters:
- N, 10: datapath width (A, B, G, OP, RES); must be at least 4.
- IMM_W, 6: immediate field width taken from OP[IMM_W-1:0] for ADDI/SUBI; must not exceed N-2.

Ports:
- CLKb  input  1  clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- OP  input  N  data bus in: operand value, or immediate when Gin is asserted.
- FN  input  4  function select, sampled with Gin.
- Ain  input  1  load A from OP.
- Bin  input  1  load B from OP.
- Gin  input  1  start operation.
- Gout  input  1  drive RES.
- RES  output  N  G when Gout=1, else 0 (combinational gate).
- BUSY  output  1  high whenever the FSM is not in IDLE.
- DONE  output  1  one-cycle pulse after G and flags are written.
- FLAGS  output  4  registered {Z,N,C,V}.

Behaviour:
- Reset (asynchronous): A=B=G=0, FLAGS=0, state=IDLE, BUSY=0, DONE=0. RES therefore reads 0. Reset mid-operation aborts it, and no DONE is produced.
- Operand loads:
  - Ain=1 at an edge: A<=OP. Bin=1 at an edge: B<=OP. Both may be asserted in the same cycle.
  - Loads are accepted in any state. A running operation uses the working copies taken at start, so loads do not affect it.
- FN encoding:
  - 0010 ADD A+B; 0011 SUB A-B; 0100 INV (~A)+1; 0101 FLP ~A; 0110 AND; 0111 OR.
  - 1000 XOR; 1001 LSL A<<B; 1010 LSR A>>B; 1011 ASR A>>>B (sign fill).
  - 1100 ADDI A+zext(OP[IMM_W-1:0]); 1101 SUBI A-zext(imm); 1110 MUL (optional).
  - All other codes are invalid.
- FSM states: IDLE, EXEC, SHIFT, MUL, DONE_S.
  - IDLE with Gin=1 at an edge: capture FN, A, B and the immediate into working registers.
    - Shifts go to SHIFT with count=min(B,N).
    - MUL goes to MUL (only when compiled in).
    - Everything else goes to EXEC.
  - IDLE with Gin=0: remain in IDLE.
  - EXEC: write G and FLAGS, then go to DONE_S. Latency is 2 edges from Gin to G.
  - SHIFT: shift the working value by 1 bit per edge and decrement count. When count reaches 0, write G/FLAGS and go to DONE_S.
    - A count of 0 writes the unchanged A on the first SHIFT edge.
    - Gin-to-G latency is 2+min(B,N) edges. B of N or more yields full shift-out (0, or all sign bits for ASR).
  - DONE_S: DONE=1 for exactly this cycle, then return to IDLE.
  - Gin while BUSY is ignored; nothing is queued.
- Arithmetic: modulo 2^N.
- Flags:
  - Z = (G==0); N = G[N-1].
  - ADD/ADDI: C = carry out.
  - SUB/SUBI: C = 1 when no borrow (A >= operand, unsigned).
  - V = two's-complement overflow for ADD/SUB/ADDI/SUBI/INV (INV: V=1 only when A=100..0).
  - Shifts: C = last bit shifted out (0 if count=0); V=0.
  - Logic ops: C=V=0.
- Invalid FN: goes through EXEC and writes G=0, Z=1, other flags 0. DONE is still pulsed.

Optional Feature:
- Macro ALU_MUL_EN.
- Defined: FN=1110 enters MUL and performs unsigned shift-add multiply, one partial product per edge, N edges in MUL.
  - G = low N bits of A*B.
  - C = 1 if the upper N bits are non-zero; V=0.
  - Gin-to-G latency is N+1 edges.
- Undefined: the MUL state and its multiplier logic are absent. FN=1110 is treated as invalid (G=0, Z=1, 2-edge latency).

Test Plan:
1. Reset; Ain OP=100; Bin OP=23; Gin FN=0010 -> G=123 two edges after Gin, DONE one cycle, FLAGS=0000. RES=0 with Gout=0 and RES=123 with Gout=1.
2. A=511, B=1, ADD -> G=10'h200, FLAGS Z0 N1 C0 V1. A=5, B=5, SUB -> G=0, Z1 C1 V0.
3. A=10'b1000000001, B=3, ASR -> BUSY for 5 cycles, G=10'b1111000000, C=0. A=1, B=12, LSL -> G=0, C=1, result written after 10 shift edges.
4. A=5, Gin FN=1100 with OP[5:0]=63 -> G=68. A=5, FN=1101, imm=6 -> G=10'h3FF, N=1, C=0.
5. Start LSR with B=8; mid-shift assert Gin (ignored) and Ain OP=0 -> result uses the original A, and A reads 0 afterwards. A second run with RST asserted mid-shift -> BUSY=0, G=0, no DONE.
6. With ALU_MUL_EN: A=31, B=33 -> G=1023, C=0. A=32, B=32 -> G=0, Z=1, C=1, latency 11 edges. Without the macro: FN=1110 -> G=0, Z=1. Also FN=1111 -> G=0, Z=1, DONE pulsed.
